pcm_apb_feeder: RTL and testbench

PCM_APB_FEEDER -- requirements
Module: pcm_apb_feeder

---
 rtl/pcm_apb_feeder.sv | 125 ++++++++++++
 tb/tb_pcm_apb_feeder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_apb_feeder.sv
// Drains buffered PCM samples into an APB transceiver's transmit register.
// Before each write it polls the flags register and backs off while the TxFIFO reports full.
module pcm_apb_feeder #(
  parameter logic [31:0] ADR_OFFSET = 32'h0,
  parameter logic [31:0] TX_REG     = 32'h0,
  parameter logic [31:0] FLAG_REG   = 32'h8,
  parameter int unsigned FULL_BIT   = 7,
  parameter int unsigned POLL_GAP   = 8
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        en,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic        pwrite,
  output logic        penable,
  input  logic [31:0] prdata,
  output logic        busy,
  output logic [15:0] sent_cnt
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StRdSetup  = 3'd1;
  localparam logic [2:0] StRdAccess = 3'd2;
  localparam logic [2:0] StCheck    = 3'd3;
  localparam logic [2:0] StBackoff  = 3'd4;
  localparam logic [2:0] StWrSetup  = 3'd5;
  localparam logic [2:0] StWrAccess = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [7:0]  bo_cnt_q, bo_cnt_d;
  logic [31:0] mem_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q;
  logic [31:0] flag_q;
  logic [31:0] paddr_q, pwdata_q;
  logic        pwrite_q, penable_q;
  logic [15:0] sent_cnt_q;
  logic        fifo_full, fifo_empty, push, pop;
  logic        unused_flag;

  assign fifo_full   = (count_q == 3'd4);
  assign fifo_empty  = (count_q == 3'd0);
  assign push        = s_valid && !fifo_full;
  assign pop         = (state_q == StWrAccess);
  assign unused_flag = ^flag_q;

  always_comb begin
    state_d  = state_q;
    bo_cnt_d = bo_cnt_q;
    case (state_q)
      StIdle:     if (en && !fifo_empty) state_d = StRdSetup;
      StRdSetup:  state_d = StRdAccess;
      StRdAccess: state_d = StCheck;
      StCheck: begin
        if (!en) begin
          state_d = StIdle;
        end else if (flag_q[FULL_BIT]) begin
          state_d  = StBackoff;
          bo_cnt_d = 8'(POLL_GAP);
        end else begin
          state_d = StWrSetup;
        end
      end
      StBackoff: begin
        // Counter runs POLL_GAP..0, so the next poll starts POLL_GAP+4 cycles after the last.
        if (bo_cnt_q == 8'd0) state_d = en ? StRdSetup : StIdle;
        else                  bo_cnt_d = bo_cnt_q - 8'd1;
      end
      StWrSetup:  state_d = StWrAccess;
      StWrAccess: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Sample storage needs no reset; the pointers define what is valid.
  always_ff @(posedge pclk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge pclk) begin
    if (!preset) begin
      state_q    <= StIdle;
      bo_cnt_q   <= 8'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      flag_q     <= 32'h0;
      paddr_q    <= 32'h0;
      pwdata_q   <= 32'h0;
      pwrite_q   <= 1'b0;
      penable_q  <= 1'b0;
      sent_cnt_q <= 16'h0;
    end else begin
      state_q  <= state_d;
      bo_cnt_q <= bo_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      if (push && !pop)      count_q <= count_q + 3'd1;
      else if (!push && pop) count_q <= count_q - 3'd1;
      if (state_q == StRdAccess) flag_q <= prdata;
      if (pop) sent_cnt_q <= sent_cnt_q + 16'd1;
      // APB outputs are registered from the next state so they line up with each phase.
      pwrite_q  <= (state_d == StWrSetup) || (state_d == StWrAccess);
      penable_q <= (state_d == StRdAccess) || (state_d == StWrAccess);
      if (state_d == StRdSetup) paddr_q <= ADR_OFFSET + FLAG_REG;
      if (state_d == StWrSetup) begin
        paddr_q  <= ADR_OFFSET + TX_REG;
        pwdata_q <= mem_q[rd_ptr_q];
      end
    end
  end

  assign s_ready  = !fifo_full;
  assign paddr    = paddr_q;
  assign pwdata   = pwdata_q;
  assign pwrite   = pwrite_q;
  assign penable  = penable_q;
  assign busy     = (state_q != StIdle);
  assign sent_cnt = sent_cnt_q;

endmodule

// File: tb/tb_pcm_apb_feeder.sv
// Directed bench for pcm_apb_feeder with a simple APB slave that scripts the flags reads.
module tb_pcm_apb_feeder;

  logic        pclk = 1'b0;
  logic        preset, en, s_valid, s_ready;
  logic [31:0] s_data, paddr, pwdata, prdata;
  logic        pwrite, penable, busy;
  logic [15:0] sent_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  int cyc = 0;
  int polls_seen = 0;
  int poll_base  = 0;
  int busy_polls = 0;
  int rd_log[$];
  logic [63:0] wr_log[$];

  pcm_apb_feeder dut (
    .pclk    (pclk),
    .preset  (preset),
    .en      (en),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pwrite  (pwrite),
    .penable (penable),
    .prdata  (prdata),
    .busy    (busy),
    .sent_cnt(sent_cnt)
  );

  always #5 pclk = ~pclk;

  // Flags word: bit7 set for the first busy_polls reads, other bits toggled to expose bad indexing.
  assign prdata = ((polls_seen - poll_base) < busy_polls) ? 32'hFFFF_FF80 : 32'h0000_007F;

  always @(posedge pclk) begin
    cyc <= cyc + 1;
    if (preset && penable && !pwrite) begin
      polls_seen <= polls_seen + 1;
      rd_log.push_back(cyc);
    end
    if (preset && penable && pwrite) wr_log.push_back({paddr, pwdata});
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    preset = 1'b0;
    tick();
    preset = 1'b1;
  endtask

  task automatic test_reset();
    preset = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = 32'h0;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
    n_checks++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready got %0b want 1", s_ready); else n_pass++;
    n_checks++; if (pwrite !== 1'b0) $display("FAIL reset_pwrite got %0b want 0", pwrite); else n_pass++;
    n_checks++; if (penable !== 1'b0) $display("FAIL reset_penable got %0b want 0", penable); else n_pass++;
    n_checks++; if (paddr !== 32'h0) $display("FAIL reset_paddr got %h want 0", paddr); else n_pass++;
    n_checks++; if (pwdata !== 32'h0) $display("FAIL reset_pwdata got %h want 0", pwdata); else n_pass++;
    n_checks++; if (sent_cnt !== 16'h0) $display("FAIL reset_sent_cnt got %0d want 0", sent_cnt); else n_pass++;
    preset = 1'b1;
  endtask

  task automatic test_single();
    logic [34:0] exp_tbl [6];
    logic [34:0] obs;
    exp_tbl[0] = {3'b100, 32'h8};  // RD_SETUP
    exp_tbl[1] = {3'b101, 32'h8};  // RD_ACCESS
    exp_tbl[2] = {3'b100, 32'h8};  // CHECK
    exp_tbl[3] = {3'b110, 32'h0};  // WR_SETUP
    exp_tbl[4] = {3'b111, 32'h0};  // WR_ACCESS
    exp_tbl[5] = {3'b000, 32'h0};  // IDLE
    en = 1'b1; busy_polls = 0;
    s_valid = 1'b1; s_data = 32'hA5A5_0001;
    tick();
    s_valid = 1'b0; s_data = 32'hDEAD_BEEF;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_idle_after_push got %0b want 0", busy); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      tick();
      obs = {busy, pwrite, penable, paddr};
      n_checks++;
      if (obs !== exp_tbl[k]) $display("FAIL single_phase%0d {busy,pwrite,penable,paddr} got %h want %h", k + 1, obs, exp_tbl[k]);
      else n_pass++;
      if (k == 3 || k == 4) begin
        n_checks++;
        if (pwdata !== 32'hA5A5_0001) $display("FAIL single_pwdata%0d got %h want a5a50001", k + 1, pwdata);
        else n_pass++;
      end
    end
    n_checks++; if (sent_cnt !== 16'd1) $display("FAIL single_sent_cnt got %0d want 1", sent_cnt); else n_pass++;
  endtask

  task automatic test_poll();
    int rb, wb, t;
    busy_polls = 2; poll_base = polls_seen;
    rb = rd_log.size(); wb = wr_log.size();
    s_valid = 1'b1; s_data = 32'h1111_2222;
    tick();
    s_valid = 1'b0;
    t = 0;
    while (wr_log.size() == wb && t < 200) begin tick(); t++; end
    n_checks++; if (wr_log.size() == wb) $display("FAIL poll_timeout got 0 writes want 1"); else n_pass++;
    n_checks++;
    if (rd_log.size() - rb != 3) $display("FAIL poll_reads got %0d want 3", rd_log.size() - rb); else n_pass++;
    if (rd_log.size() - rb >= 3) begin
      n_checks++;
      if (rd_log[rb+1] - rd_log[rb] != 12) $display("FAIL poll_gap1 got %0d want 12", rd_log[rb+1] - rd_log[rb]);
      else n_pass++;
      n_checks++;
      if (rd_log[rb+2] - rd_log[rb+1] != 12) $display("FAIL poll_gap2 got %0d want 12", rd_log[rb+2] - rd_log[rb+1]);
      else n_pass++;
    end
    if (wr_log.size() > wb) begin
      n_checks++;
      if (wr_log[wb] !== {32'h0, 32'h1111_2222}) $display("FAIL poll_write got %h want 0000000011112222", wr_log[wb]);
      else n_pass++;
    end
    n_checks++; if (sent_cnt !== 16'd2) $display("FAIL poll_sent_cnt got %0d want 2", sent_cnt); else n_pass++;
    busy_polls = 0;
  endtask

  task automatic test_back_to_back();
    int acc, wb, t;
    logic was_ready;
    do_reset();
    en = 1'b1; acc = 0; wb = wr_log.size();
    for (int i = 0; i < 100 && acc < 6; i++) begin
      s_valid = 1'b1; s_data = 32'hB000_0000 + acc;
      was_ready = s_ready;
      tick();
      if (was_ready) begin
        acc++;
        if (acc == 4) begin
          n_checks++;
          if (s_ready !== 1'b0) $display("FAIL burst_full_s_ready got %0b want 0", s_ready); else n_pass++;
        end
      end
    end
    s_valid = 1'b0;
    n_checks++; if (acc != 6) $display("FAIL burst_accepted got %0d want 6", acc); else n_pass++;
    t = 0;
    while (wr_log.size() < wb + 6 && t < 300) begin tick(); t++; end
    n_checks++; if (wr_log.size() < wb + 6) $display("FAIL burst_timeout got %0d writes want 6", wr_log.size() - wb); else n_pass++;
    for (int k = 0; k < 6 && (wb + k) < wr_log.size(); k++) begin
      n_checks++;
      if (wr_log[wb+k] !== {32'h0, 32'hB000_0000 + k}) $display("FAIL burst_write%0d got %h want %h", k, wr_log[wb+k], {32'h0, 32'hB000_0000 + k});
      else n_pass++;
    end
    n_checks++; if (sent_cnt !== 16'd6) $display("FAIL burst_sent_cnt got %0d want 6", sent_cnt); else n_pass++;
  endtask

  task automatic test_en_drop();
    int rb, wb, t;
    do_reset();
    en = 1'b1; wb = wr_log.size();
    s_valid = 1'b1; s_data = 32'hC000_0001; tick();
    s_data = 32'hC000_0002; tick();
    s_valid = 1'b0;
    t = 0;
    while (!(pwrite && !penable) && t < 50) begin tick(); t++; end
    n_checks++; if (!(pwrite && !penable)) $display("FAIL endrop_timeout got no WR_SETUP want WR_SETUP"); else n_pass++;
    en = 1'b0; rb = rd_log.size();
    for (int i = 0; i < 30; i++) tick();
    n_checks++; if (wr_log.size() - wb != 1) $display("FAIL endrop_writes got %0d want 1", wr_log.size() - wb); else n_pass++;
    if (wr_log.size() > wb) begin
      n_checks++;
      if (wr_log[wb] !== {32'h0, 32'hC000_0001}) $display("FAIL endrop_data got %h want 00000000c0000001", wr_log[wb]);
      else n_pass++;
    end
    n_checks++; if (rd_log.size() != rb) $display("FAIL endrop_reads got %0d want 0", rd_log.size() - rb); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL endrop_busy got %0b want 0", busy); else n_pass++;
    n_checks++; if (sent_cnt !== 16'd1) $display("FAIL endrop_sent_cnt got %0d want 1", sent_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int rb, t;
    en = 1'b1; t = 0;
    while (!(penable && !pwrite) && t < 50) begin tick(); t++; end
    n_checks++; if (!(penable && !pwrite)) $display("FAIL rstmid_timeout got no RD_ACCESS want RD_ACCESS"); else n_pass++;
    preset = 1'b0;
    tick();
    n_checks++; if (penable !== 1'b0) $display("FAIL rstmid_penable got %0b want 0", penable); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %0b want 0", busy); else n_pass++;
    n_checks++; if (sent_cnt !== 16'd0) $display("FAIL rstmid_sent_cnt got %0d want 0", sent_cnt); else n_pass++;
    n_checks++; if (s_ready !== 1'b1) $display("FAIL rstmid_s_ready got %0b want 1", s_ready); else n_pass++;
    preset = 1'b1; rb = rd_log.size();
    for (int i = 0; i < 20; i++) tick();
    n_checks++; if (rd_log.size() != rb) $display("FAIL rstmid_discard got %0d reads want 0", rd_log.size() - rb); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_idle got %0b want 0", busy); else n_pass++;
  endtask

  task automatic test_wrap();
    int wb, t;
    force dut.sent_cnt_q = 16'hFFFF;
    tick();
    release dut.sent_cnt_q;
    n_checks++; if (sent_cnt !== 16'hFFFF) $display("FAIL wrap_preload got %h want ffff", sent_cnt); else n_pass++;
    wb = wr_log.size();
    s_valid = 1'b1; s_data = 32'hE000_0001; tick();
    s_valid = 1'b0; t = 0;
    while (wr_log.size() == wb && t < 50) begin tick(); t++; end
    n_checks++; if (wr_log.size() == wb) $display("FAIL wrap_timeout got 0 writes want 1"); else n_pass++;
    n_checks++; if (sent_cnt !== 16'h0) $display("FAIL wrap_sent_cnt got %h want 0000", sent_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_poll();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
